stage_ic_buffer: RTL and testbench

- Complete-stage buffer directly downstream of the execute stage.
- Accepts one finished EX result per cycle, holds it in an in-order FIFO, and presents the oldest entry to the CDB arbiter.
- On CDB grant it broadcasts the tag/data to RS/PRF consumers and marks the ROB entry complete (taken-branch flag and halt/illegal included).
- A ROB flush synchronously squashes all buffered results.

---
 rtl/stage_ic_buffer.sv | 135 +++++++++++++
 tb/tb_stage_ic_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_ic_buffer.sv
// Complete-stage buffer: an in-order FIFO of finished EX results that feeds the CDB arbiter.
// The head entry drives the CDB and ROB completion outputs. A flush empties the buffer.
module stage_ic_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int PREG_BITS = 6,
  parameter int ROB_BITS  = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [XLEN-1:0]        ex_result,
  input  logic [XLEN-1:0]        ex_npc,
  input  logic                   ex_take_branch,
  input  logic                   ex_dest_valid,
  input  logic [PREG_BITS-1:0]   ex_dest_tag,
  input  logic [ROB_BITS-1:0]    ex_rob_idx,
  input  logic                   ex_halt,
  input  logic                   ex_illegal,
  input  logic                   cdb_ready,
  output logic                   cdb_valid,
  output logic                   cdb_tag_valid,
  output logic [PREG_BITS-1:0]   cdb_tag,
  output logic [XLEN-1:0]        cdb_data,
  output logic [ROB_BITS-1:0]    rob_idx,
  output logic                   rob_take_branch,
  output logic [XLEN-1:0]        rob_npc,
  output logic                   rob_halt,
  output logic                   rob_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      npc;
    logic                 take_branch;
    logic                 dest_valid;
    logic [PREG_BITS-1:0] dest_tag;
    logic [ROB_BITS-1:0]  rob_idx;
    logic                 halt;
    logic                 illegal;
  } entry_t;

  entry_t            entry_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  entry_t            ex_entry;
  entry_t            head_entry;
  logic              enq, deq;

  always_comb begin
    ex_entry.result      = ex_result;
    ex_entry.npc         = ex_npc;
    ex_entry.take_branch = ex_take_branch;
    ex_entry.dest_valid  = ex_dest_valid;
    ex_entry.dest_tag    = ex_dest_tag;
    ex_entry.rob_idx     = ex_rob_idx;
    ex_entry.halt        = ex_halt;
    ex_entry.illegal     = ex_illegal;
  end

  // Readiness depends only on occupancy, so a full buffer refuses even when draining.
  assign ex_ready  = (count_q != CW'(DEPTH));
  assign cdb_valid = valid_q[head_q];
  assign enq       = ex_valid && ex_ready && !flush;
  assign deq       = cdb_valid && cdb_ready && !flush;
  assign count     = count_q;

  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (flush) begin
        valid_q <= '0;
      end else begin
        // enq and deq never target the same slot: full blocks enq, empty blocks deq.
        if (deq) valid_q[head_q] <= 1'b0;
        if (enq) valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; the valid bits alone gate visibility.
  always_ff @(posedge clock) begin
    if (enq) entry_q[tail_q] <= ex_entry;
  end

  assign head_entry = entry_q[head_q];

  always_comb begin
    cdb_tag_valid   = 1'b0;
    cdb_tag         = '0;
    cdb_data        = '0;
    rob_idx         = '0;
    rob_take_branch = 1'b0;
    rob_npc         = '0;
    rob_halt        = 1'b0;
    rob_illegal     = 1'b0;
    if (cdb_valid) begin
      cdb_tag_valid   = head_entry.dest_valid && (head_entry.dest_tag != '0);
      cdb_tag         = head_entry.dest_tag;
      cdb_data        = head_entry.result;
      rob_idx         = head_entry.rob_idx;
      rob_take_branch = head_entry.take_branch;
      rob_npc         = head_entry.npc;
      rob_halt        = head_entry.halt;
      rob_illegal     = head_entry.illegal;
    end
  end

endmodule

// File: tb/tb_stage_ic_buffer.sv
// Directed bench for stage_ic_buffer: a queue holds the expected buffer contents,
// and the head of that queue is compared with the CDB/ROB outputs every cycle.
module tb_stage_ic_buffer;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 4;
  localparam int PREG_BITS = 6;
  localparam int ROB_BITS  = 5;

  logic                   clock = 1'b0;
  logic                   reset, flush, ex_valid, ex_ready;
  logic [XLEN-1:0]        ex_result, ex_npc;
  logic                   ex_take_branch, ex_dest_valid;
  logic [PREG_BITS-1:0]   ex_dest_tag;
  logic [ROB_BITS-1:0]    ex_rob_idx;
  logic                   ex_halt, ex_illegal, cdb_ready;
  logic                   cdb_valid, cdb_tag_valid;
  logic [PREG_BITS-1:0]   cdb_tag;
  logic [XLEN-1:0]        cdb_data;
  logic [ROB_BITS-1:0]    rob_idx;
  logic                   rob_take_branch;
  logic [XLEN-1:0]        rob_npc;
  logic                   rob_halt, rob_illegal;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      npc;
    logic                 tb;
    logic                 dv;
    logic [PREG_BITS-1:0] tag;
    logic [ROB_BITS-1:0]  rob;
    logic                 halt;
    logic                 ill;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  stage_ic_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .PREG_BITS(PREG_BITS), .ROB_BITS(ROB_BITS)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_npc(ex_npc), .ex_take_branch(ex_take_branch),
    .ex_dest_valid(ex_dest_valid), .ex_dest_tag(ex_dest_tag), .ex_rob_idx(ex_rob_idx),
    .ex_halt(ex_halt), .ex_illegal(ex_illegal), .cdb_ready(cdb_ready),
    .cdb_valid(cdb_valid), .cdb_tag_valid(cdb_tag_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .rob_idx(rob_idx), .rob_take_branch(rob_take_branch),
    .rob_npc(rob_npc), .rob_halt(rob_halt), .rob_illegal(rob_illegal), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [PREG_BITS-1:0] tag, input logic [XLEN-1:0] res,
                        input logic [ROB_BITS-1:0] rob, input logic dv, input logic tb,
                        input logic [XLEN-1:0] npc, input logic halt, input logic ill);
    ex_valid = v; ex_dest_tag = tag; ex_result = res; ex_rob_idx = rob;
    ex_dest_valid = dv; ex_take_branch = tb; ex_npc = npc; ex_halt = halt; ex_illegal = ill;
  endtask

  task automatic check_outputs(input string where);
    ent_t e;
    logic v;
    v = (sb.size() != 0);
    e = '{result: '0, npc: '0, tb: 1'b0, dv: 1'b0, tag: '0, rob: '0, halt: 1'b0, ill: 1'b0};
    if (v) e = sb[0];
    $display("[%0t] %s: count=%0d cdb_valid=%0b tag=%0d data=%h rob=%0d (expect size %0d)",
             $time, where, count, cdb_valid, cdb_tag, cdb_data, rob_idx, sb.size());
    chk({where, ".count_bound"}, 64'(count <= DEPTH), 64'd1);
    chk({where, ".count"}, 64'(count), 64'(sb.size()));
    chk({where, ".ex_ready"}, 64'(ex_ready), 64'(sb.size() != DEPTH));
    chk({where, ".cdb_valid"}, 64'(cdb_valid), 64'(v));
    chk({where, ".cdb_tag_valid"}, 64'(cdb_tag_valid), 64'(v && e.dv && (e.tag != 0)));
    chk({where, ".cdb_tag"}, 64'(cdb_tag), 64'(e.tag));
    chk({where, ".cdb_data"}, 64'(cdb_data), 64'(e.result));
    chk({where, ".rob_idx"}, 64'(rob_idx), 64'(e.rob));
    chk({where, ".rob_take_branch"}, 64'(rob_take_branch), 64'(e.tb));
    chk({where, ".rob_npc"}, 64'(rob_npc), 64'(e.npc));
    chk({where, ".rob_halt"}, 64'(rob_halt), 64'(e.halt));
    chk({where, ".rob_illegal"}, 64'(rob_illegal), 64'(e.ill));
  endtask

  // Check current outputs, advance the model by one edge, then step the clock.
  task automatic cycle(input string where);
    bit do_enq, do_deq;
    ent_t n;
    check_outputs(where);
    do_enq = ex_valid && (sb.size() < DEPTH) && !flush;
    do_deq = cdb_ready && (sb.size() != 0) && !flush;
    n = '{result: ex_result, npc: ex_npc, tb: ex_take_branch, dv: ex_dest_valid,
          tag: ex_dest_tag, rob: ex_rob_idx, halt: ex_halt, ill: ex_illegal};
    if (flush) sb.delete();
    if (do_deq) void'(sb.pop_front());
    if (do_enq) sb.push_back(n);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; cdb_ready = 1'b0;
    set_ex(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    reset = 1'b0;
    cycle("idle");

    // Reset asserted mid-stream with two entries buffered
    set_ex(1'b1, 6'd7, 32'h11, 5'd1, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0);
    cycle("rst_fill0");
    set_ex(1'b1, 6'd8, 32'h22, 5'd2, 1'b1, 1'b0, 32'h44, 1'b0, 1'b0);
    cycle("rst_fill1");
    ex_valid = 1'b0;
    check_outputs("rst_before");
    reset = 1'b1;
    #1;
    sb.delete();
    chk("async_rst.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst.count", 64'(count), 64'd0);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single pass-through
    cdb_ready = 1'b1;
    set_ex(1'b1, 6'd5, 32'h0000_002A, 5'd3, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
    cycle("pass_c0");
    ex_valid = 1'b0;
    chk("pass_c1.cdb_tag_exact", 64'(cdb_tag), 64'd5);
    chk("pass_c1.cdb_data_exact", 64'(cdb_data), 64'h2A);
    cycle("pass_c1");
    cycle("pass_c2");

    // Back-pressure: fill to DEPTH, fifth enqueue refused, then drain in order
    cdb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_ex(1'b1, PREG_BITS'(i), $urandom, ROB_BITS'(i + 8), 1'b1, 1'b0, $urandom, 1'b0, 1'b0);
      cycle($sformatf("bp_fill%0d", i));
    end
    set_ex(1'b1, 6'd5, 32'hDEAD_BEEF, 5'd13, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_full.ex_ready", 64'(ex_ready), 64'd0);
    cycle("bp_refuse");
    ex_valid = 1'b0;
    cdb_ready = 1'b1;
    for (int i = 1; i <= 5; i++) cycle($sformatf("bp_drain%0d", i));

    // Steady streaming at count 2, pointers wrapping several times
    cdb_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_ex(1'b1, PREG_BITS'(10 + i), $urandom, ROB_BITS'(i), 1'b1, 1'b0, $urandom, 1'b0, 1'b0);
      cycle($sformatf("stream_pre%0d", i));
    end
    cdb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ex(1'b1, PREG_BITS'(12 + i), $urandom, ROB_BITS'(2 + i), 1'b1, 1'b0, $urandom, 1'b0, 1'b0);
      cycle($sformatf("stream%0d", i));
    end
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle($sformatf("stream_drain%0d", i));

    // Flush with three buffered entries and a simultaneous enqueue
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, PREG_BITS'(30 + i), $urandom, ROB_BITS'(20 + i), 1'b1, 1'b0, $urandom, 1'b0, 1'b0);
      cycle($sformatf("flush_fill%0d", i));
    end
    flush = 1'b1;
    set_ex(1'b1, 6'd9, 32'h9999, 5'd9, 1'b1, 1'b0, 32'h900, 1'b0, 1'b0);
    cycle("flush");
    flush = 1'b0;
    ex_valid = 1'b0;
    cdb_ready = 1'b1;
    chk("flush_after.count", 64'(count), 64'd0);
    chk("flush_after.cdb_valid", 64'(cdb_valid), 64'd0);
    cycle("flush_after0");
    cycle("flush_after1");

    // No-dest branch, tag-0 write, and halt/illegal flags
    cdb_ready = 1'b0;
    set_ex(1'b1, 6'd3, 32'h77, 5'd4, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    cycle("nodest_enq");
    set_ex(1'b1, 6'd0, 32'h88, 5'd5, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0);
    cycle("tag0_enq");
    set_ex(1'b1, 6'd6, 32'h99, 5'd6, 1'b1, 1'b0, 32'h108, 1'b1, 1'b1);
    cycle("halt_enq");
    ex_valid = 1'b0;
    chk("nodest.cdb_tag_valid", 64'(cdb_tag_valid), 64'd0);
    chk("nodest.rob_take_branch", 64'(rob_take_branch), 64'd1);
    chk("nodest.rob_npc", 64'(rob_npc), 64'h100);
    cdb_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle($sformatf("special_drain%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
